instruction_cache: RTL and testbench
====================================

// Module: instruction_cache
// PURPOSE
//  Direct-mapped, one-word-per-line instruction cache between the fetch unit and the
//  memory controller's icache port. Hits return the instruction in the request cycle.
//  Misses issue one 32-bit word request to the memory controller, fill the line and
//  forward the word. Outstanding misses are abandoned on branch-mispredict clear.
// PARAMETERS
//  INDEX_WIDTH  4  log2(line count); index = addr[INDEX_WIDTH+1:2], tag = addr[31:INDEX_WIDTH+2]
// PORTS
//  clockIn     in   1   single clock, rising edge
//  resetIn     in   1   asynchronous, active-high reset
//  readyIn     in   1   global enable; state frozen when low
//  clearIn     in   1   mispredict flush (sampled only with readyIn)
//  fetchFlag   in   1   fetch request valid; held with fetchAddr until fetchOk or clearIn
//  fetchAddr   in   32  instruction address (bits [1:0] ignored)
//  fetchOk     out  1   instruction valid this cycle (combinational)
//  fetchInst   out  32  instruction word, valid when fetchOk
//  memFlag     out  1   to memory controller icacheFlag
//  memAddr     out  32  to memory controller icacheAddr, word aligned
//  memOk       in   1   from memory controller icacheOk; registered, stays high while readyIn low
//  memData     in   32  from memory controller dataOut, valid with memOk
//  hitCount    out  32  ICACHE_PERF_EN only: accepted hits
//  missCount   out  32  ICACHE_PERF_EN only: accepted misses
// BEHAVIOUR
//  Storage: valid[2^INDEX_WIDTH], tag array, data array; registers state, missAddr.
//  Reset (async): state=IDLE, all valid=0, missAddr=0, counters=0 -> fetchOk=0, memFlag=0, memAddr=0.
//  hit = valid[idx] & tag[idx]==fetchAddr tag. All updates require readyIn=1.
//  IDLE:
//   - fetchOk = readyIn & fetchFlag & hit & ~clearIn; fetchInst = data[idx].
//   - fetchFlag & ~hit & ~clearIn & readyIn -> MISS; missAddr <= {fetchAddr[31:2],2'b00}.
//  MISS:
//   - memAddr = missAddr. memFlag = ~(readyIn & memOk), which drops in the memOk cycle
//     so the controller, back in its IDLE, does not start a redundant fetch.
//   - readyIn & memOk: write data/tag, set valid for missAddr index (even if clearIn);
//     fetchOk = ~clearIn, fetchInst = memData; -> IDLE.
//   - readyIn & clearIn & ~memOk: -> IDLE, no fill; memFlag 0 from next cycle.
//  Latency: hit 0 cycles; miss = controller latency, returned in the memOk cycle.
//  readyIn=0: no state, array, or counter change; fetchOk=0; memFlag held.
//  Hit and fill never collide: fills occur only in MISS, hits only in IDLE.
//  memOk in IDLE is ignored. Fetch never stalls on a hit. Address wraps at 2^32 naturally.
// CONFIGURATION
//  ICACHE_PERF_EN defined: hitCount increments on each fetchOk in IDLE; missCount increments
//   on each IDLE->MISS transition. Both are 32-bit wrapping and reset to 0.
//  Undefined: ports and counters are absent; no other behaviour change.
// TESTING (INDEX_WIDTH=4)
//  1 Reset, fetch 0x1000 -> memFlag=1, memAddr=0x1000; memOk, memData=0x00500093 -> fetchOk=1,
//    fetchInst=0x00500093, memFlag=0 same cycle; refetch 0x1000 -> fetchOk same cycle, memFlag stays 0.
//  2 Fill 0x1000, then fetch 0x1040 (same index) -> miss and replace; fetch 0x1000 -> misses again.
//  3 clearIn in MISS before memOk -> memFlag=0 next cycle, IDLE; re-fetch same address -> miss.
//  4 clearIn with memOk -> fetchOk=0, line filled; next fetch of that address hits.
//  5 MISS with memOk=1, readyIn=0 for 3 cycles -> no fill, fetchOk=0; readyIn=1 -> exactly one fill/fetchOk.
//  6 Assert resetIn async mid-MISS -> memFlag=0 immediately, all lines invalid; with ICACHE_PERF_EN,
//    after cases 1-2 before reset: hitCount=1, missCount=3.

Source files
------------

// File: rtl/instruction_cache.sv
`default_nettype none
// ============================================================================
// Module : instruction_cache
// Brief  : Direct-mapped, one-word-per-line instruction cache. Optional hit and
//          miss counters are built when ICACHE_PERF_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
module instruction_cache #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic        clockIn,
  input  logic        resetIn,
  input  logic        readyIn,
  input  logic        clearIn,
  input  logic        fetchFlag,
  input  logic [31:0] fetchAddr,
  output logic        fetchOk,
  output logic [31:0] fetchInst,
  output logic        memFlag,
  output logic [31:0] memAddr,
  input  logic        memOk,
  input  logic [31:0] memData
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hitCount,
  output logic [31:0] missCount
`endif
);

  localparam int LINES     = 2 ** INDEX_WIDTH;
  localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MISS = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_nextState;
  logic [LINES-1:0]       r_valid;
  logic [TAG_WIDTH-1:0]   r_tag  [LINES];
  logic [31:0]            r_data [LINES];
  logic [31:0]            r_missAddr;

  logic [INDEX_WIDTH-1:0] w_fetchIdx;
  logic [INDEX_WIDTH-1:0] w_fillIdx;
  logic [TAG_WIDTH-1:0]   w_fetchTag;
  logic [TAG_WIDTH-1:0]   w_fillTag;
  logic                   w_hit;
  logic                   w_fill;
  logic                   w_startMiss;
  logic                   w_idleHit;
  logic [1:0]             w_unusedAddrBits;

  assign w_fetchIdx       = fetchAddr[INDEX_WIDTH+1:2];
  assign w_fetchTag       = fetchAddr[31:INDEX_WIDTH+2];
  assign w_fillIdx        = r_missAddr[INDEX_WIDTH+1:2];
  assign w_fillTag        = r_missAddr[31:INDEX_WIDTH+2];
  assign w_unusedAddrBits = fetchAddr[1:0];
  assign w_hit            = r_valid[w_fetchIdx] && (r_tag[w_fetchIdx] == w_fetchTag);
  assign memAddr          = r_missAddr;

  // Every transition is qualified by readyIn, so a low readyIn freezes the FSM.
  always_comb begin
    w_nextState = r_state;
    fetchOk     = 1'b0;
    fetchInst   = r_data[w_fetchIdx];
    memFlag     = 1'b0;
    w_fill      = 1'b0;
    w_startMiss = 1'b0;
    w_idleHit   = 1'b0;
    case (r_state)
      IDLE: begin
        w_idleHit = readyIn & fetchFlag & w_hit & ~clearIn;
        fetchOk   = w_idleHit;
        if (readyIn & fetchFlag & ~w_hit & ~clearIn) begin
          w_startMiss = 1'b1;
          w_nextState = MISS;
        end
      end
      MISS: begin
        // Dropping the request in the memOk cycle keeps the controller from
        // launching a second fetch for the same word.
        memFlag   = ~(readyIn & memOk);
        fetchInst = memData;
        if (readyIn & memOk) begin
          w_fill      = 1'b1;
          fetchOk     = ~clearIn;
          w_nextState = IDLE;
        end else if (readyIn & clearIn) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      r_state    <= IDLE;
      r_valid    <= '0;
      r_missAddr <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_startMiss) r_missAddr <= {fetchAddr[31:2], 2'b00};
      if (w_fill) r_valid[w_fillIdx] <= 1'b1;
    end
  end

  // Tag and data contents are qualified by r_valid, so they need no reset.
  always_ff @(posedge clockIn) begin
    if (w_fill) begin
      r_tag[w_fillIdx]  <= w_fillTag;
      r_data[w_fillIdx] <= memData;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] r_hitCount;
  logic [31:0] r_missCount;

  always_ff @(posedge clockIn or posedge resetIn) begin
    if (resetIn) begin
      r_hitCount  <= '0;
      r_missCount <= '0;
    end else begin
      if (w_idleHit) r_hitCount <= r_hitCount + 32'd1;
      if (w_startMiss) r_missCount <= r_missCount + 32'd1;
    end
  end

  assign hitCount  = r_hitCount;
  assign missCount = r_missCount;
`else
  logic w_unusedPerf;
  assign w_unusedPerf = w_idleHit;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// ============================================================================
// Module : tb_instruction_cache
// Brief  : Scoreboard bench for instruction_cache with a line-address model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_instruction_cache;

  logic        clockIn = 1'b0;
  logic        resetIn = 1'b1;
  logic        readyIn = 1'b1;
  logic        clearIn = 1'b0;
  logic        fetchFlag = 1'b0;
  logic [31:0] fetchAddr = '0;
  logic        fetchOk;
  logic [31:0] fetchInst;
  logic        memFlag;
  logic [31:0] memAddr;
  logic        memOk = 1'b0;
  logic [31:0] memData = '0;
`ifdef ICACHE_PERF_EN
  logic [31:0] hitCount;
  logic [31:0] missCount;
`endif

  instruction_cache #(.INDEX_WIDTH(4)) dut (
    .clockIn  (clockIn),
    .resetIn  (resetIn),
    .readyIn  (readyIn),
    .clearIn  (clearIn),
    .fetchFlag(fetchFlag),
    .fetchAddr(fetchAddr),
    .fetchOk  (fetchOk),
    .fetchInst(fetchInst),
    .memFlag  (memFlag),
    .memAddr  (memAddr),
    .memOk    (memOk),
    .memData  (memData)
`ifdef ICACHE_PERF_EN
    ,
    .hitCount (hitCount),
    .missCount(missCount)
`endif
  );

  always #5 clockIn = ~clockIn;

  int          compared   = 0;
  int          mismatched = 0;
  logic [31:0] sbQ[$];
  logic [31:0] lineAddr [16];
  bit          lineValid[16];
  int          modelHits   = 0;
  int          modelMisses = 0;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0050_0093;
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Monitor: every fetchOk must match the oldest expected instruction.
  always @(negedge clockIn) begin
    if (fetchOk === 1'b1) begin
      compared++;
      if (sbQ.size() == 0) begin
        mismatched++;
        $display("FAIL unexpectedFetchOk: got fetchOk=1 inst=%h required fetchOk=0", fetchInst);
      end else begin
        logic [31:0] exp;
        exp = sbQ.pop_front();
        if (fetchInst !== exp) begin
          mismatched++;
          $display("FAIL fetchInst: got %h required %h", fetchInst, exp);
        end
      end
    end
  end

  // mode: 0 normal, 1 clear before memOk, 2 clear with memOk, 3 readyIn stall with memOk
  task automatic issue(input logic [31:0] addr, input int mode);
    logic [31:0] a;
    int          idx;
    int          lat;
    a   = {addr[31:2], 2'b00};
    idx = int'(a[5:2]);
    @(posedge clockIn); #1;
    fetchFlag = 1'b1;
    fetchAddr = addr;
    if (lineValid[idx] && lineAddr[idx] == a) begin
      modelHits++;
      sbQ.push_back(memWord(a));
      @(negedge clockIn);
      check("hitMemFlag", {31'b0, memFlag}, 32'd0);
      @(posedge clockIn); #1;
      fetchFlag = 1'b0;
      check("hitDelivered", sbQ.size(), 32'd0);
    end else begin
      modelMisses++;
      @(negedge clockIn);
      check("missIdleMemFlag", {31'b0, memFlag}, 32'd0);
      @(posedge clockIn); #1;
      lat = $urandom_range(0, 3);
      for (int i = 0; i < lat; i++) begin
        @(negedge clockIn);
        check("missMemFlag", {31'b0, memFlag}, 32'd1);
        check("missMemAddr", memAddr, a);
        @(posedge clockIn); #1;
      end
      if (mode == 1) begin
        clearIn = 1'b1;
        @(negedge clockIn);
        check("clearMemFlagHeld", {31'b0, memFlag}, 32'd1);
        @(posedge clockIn); #1;
        clearIn   = 1'b0;
        fetchFlag = 1'b0;
        @(negedge clockIn);
        check("clearMemFlagDrop", {31'b0, memFlag}, 32'd0);
        return;
      end
      memOk   = 1'b1;
      memData = memWord(a);
      if (mode == 3) begin
        readyIn = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clockIn);
          check("stallMemFlag", {31'b0, memFlag}, 32'd1);
          check("stallMemAddr", memAddr, a);
          @(posedge clockIn); #1;
        end
        readyIn = 1'b1;
      end
      if (mode == 2) clearIn = 1'b1;
      else sbQ.push_back(memWord(a));
      @(negedge clockIn);
      check("okMemFlagDrop", {31'b0, memFlag}, 32'd0);
      @(posedge clockIn); #1;
      memOk     = 1'b0;
      clearIn   = 1'b0;
      fetchFlag = 1'b0;
      lineValid[idx] = 1'b1;
      lineAddr[idx]  = a;
      check("missDelivered", sbQ.size(), 32'd0);
    end
  endtask

  task automatic checkPerf();
`ifdef ICACHE_PERF_EN
    check("hitCount", hitCount, modelHits);
    check("missCount", missCount, modelMisses);
`endif
  endtask

  initial begin
    for (int i = 0; i < 16; i++) lineValid[i] = 1'b0;
    #1;
    check("rstFetchOk", {31'b0, fetchOk}, 32'd0);
    check("rstMemFlag", {31'b0, memFlag}, 32'd0);
    check("rstMemAddr", memAddr, 32'd0);
    repeat (2) @(posedge clockIn);
    #1 resetIn = 1'b0;

    // Fill, hit, same-index replacement, and re-miss on the evicted line.
    issue(32'h0000_1000, 0);
    issue(32'h0000_1000, 0);
    issue(32'h0000_1040, 0);
    issue(32'h0000_1000, 0);
    checkPerf();
`ifdef ICACHE_PERF_EN
    check("hitCountDirected", hitCount, 32'd1);
    check("missCountDirected", missCount, 32'd3);
`endif

    issue(32'h0000_4000, 1);
    issue(32'h0000_4000, 0);
    issue(32'h0000_3000, 2);
    issue(32'h0000_3000, 0);
    issue(32'h0000_2000, 3);
    issue(32'h0000_2000, 0);
    issue(32'hFFFF_FFFC, 0);
    issue(32'hFFFF_FFFF, 0);

    for (int n = 0; n < 250; n++) begin
      logic [31:0] addr;
      int          r;
      int          mode;
      addr = 32'h0001_0000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2)
             + $urandom_range(0, 3);
      r    = $urandom_range(0, 9);
      mode = (r < 3) ? r + 1 : 0;
      issue(addr, mode);
    end
    checkPerf();

    // Asynchronous reset in the middle of a miss.
    @(posedge clockIn); #1;
    fetchFlag = 1'b1;
    fetchAddr = 32'h0000_5000;
    @(posedge clockIn); #1;
    check("preRstMemFlag", {31'b0, memFlag}, 32'd1);
    #2 resetIn = 1'b1;
    #1;
    check("asyncRstMemFlag", {31'b0, memFlag}, 32'd0);
    check("asyncRstMemAddr", memAddr, 32'd0);
    fetchFlag = 1'b0;
    for (int i = 0; i < 16; i++) lineValid[i] = 1'b0;
    modelHits   = 0;
    modelMisses = 0;
    checkPerf();
    @(posedge clockIn); #1;
    resetIn = 1'b0;
    issue(32'h0000_1000, 0);
    issue(32'h0000_1000, 0);
    checkPerf();

    repeat (2) @(posedge clockIn);
    check("scoreboardEmpty", sbQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
